// File: rtl/spi_reg_slave_pkg.sv
// Shared SPI register-access definitions, used by both the slave and the
// matching SPI master.
//   spi_state_t : frame sequencer states
//   FRAME_BITS  : full frame length (rw + address + data)
//   CMD_BITS    : command phase length (rw + address)
//   CNT_W       : width of a bit counter able to hold FRAME_BITS
package spi_reg_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

  localparam int unsigned FRAME_BITS = 27;
  localparam int unsigned CMD_BITS   = 7;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

endpackage

// File: rtl/spi_slave_regfile.sv
// Register array behind the SPI slave.
//   clk, rst_n          : system clock, asynchronous active-low reset (clears all)
//   we, wr_addr, wr_data: single synchronous write port
//   rd_addr, rd_data    : asynchronous read port
module spi_slave_regfile #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI (mode 0) register-access slave, oversampled by the system clock.
// Frame: rw (1 = read), address, data, all MSB first.
//   i_clk_sys, i_rst_n           : system clock, asynchronous active-low reset
//   i_spi_sclk/i_spi_cs_n/i_spi_mosi : raw SPI inputs (asynchronous)
//   o_spi_miso, o_spi_miso_oe    : read data out and its drive enable
//   o_wr_en/o_wr_addr/o_wr_data  : one-cycle strobe for each committed write
//   o_frame_err                  : one-cycle strobe for a truncated frame
//   o_busy                       : frame in progress
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int unsigned SPI_ADDR_WIDTH = 6,
  parameter int unsigned SPI_DATA_WIDTH = 20,
  parameter int unsigned REG_DEPTH      = 64
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_n,
  input  logic                      i_spi_sclk,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_spi_miso_oe,
  output logic                      o_wr_en,
  output logic [SPI_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [SPI_DATA_WIDTH-1:0] o_wr_data,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  localparam int unsigned AW = SPI_ADDR_WIDTH;
  localparam int unsigned DW = SPI_DATA_WIDTH;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;
  logic [1:0] settle_cnt;
  logic armed;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_prev  <= 1'b0;
      cs_meta    <= 1'b1;
      cs_sync    <= 1'b1;
      cs_prev    <= 1'b1;
      mosi_meta  <= 1'b0;
      mosi_sync  <= 1'b0;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      sclk_meta <= i_spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= i_spi_cs_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= i_spi_mosi;
      mosi_sync <= mosi_meta;
      if (settle_cnt != '1) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      // The synchronizer resets to "deselected"; if CS_n is already low when
      // reset releases, the flush would look like a fall. Only arm once CS_n
      // has genuinely been seen high after the pipeline has settled.
      if (settle_cnt == '1 && cs_sync) begin
        armed <= 1'b1;
      end
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign cs_fall   = armed & ~cs_sync & cs_prev;
  assign cs_rise   = cs_sync & ~cs_prev;

  spi_state_t       state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             cmd_done, frame_done, frame_abort;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_done    = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    unique case (state)
      ST_IDLE: if (cs_fall) state_next = ST_CMD;
      ST_CMD: begin
        if (sclk_rise && bit_cnt == CNT_W'(CMD_BITS - 1)) begin
          state_next = ST_DATA;
          cmd_done   = 1'b1;
        end
      end
      ST_DATA: begin
        if (sclk_rise && bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
          state_next = ST_DONE;
          frame_done = 1'b1;
        end
      end
      ST_DONE: ;
    endcase
    // Deselect wins over everything, but a last bit arriving in the same
    // cycle still completes the frame.
    if (cs_rise && state != ST_IDLE) begin
      state_next  = ST_IDLE;
      cmd_done    = 1'b0;
      frame_abort = (bit_cnt != '0) && (bit_cnt != CNT_W'(FRAME_BITS)) && !frame_done;
    end
  end

  logic          shift_en, rw_bit, load_tx, wr_stb, tx_active;
  logic [DW-2:0] rx_shift;
  logic [DW-1:0] tx_shift, wr_data, rd_data;
  logic [AW-1:0] addr;

  assign shift_en  = sclk_rise && (state == ST_CMD || state == ST_DATA);
  assign wr_data   = {rx_shift, mosi_sync};
  assign wr_stb    = frame_done && !rw_bit;
  assign tx_active = (state == ST_DATA) && rw_bit;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rw_bit      <= 1'b0;
      addr        <= '0;
      load_tx     <= 1'b0;
      tx_shift    <= '0;
      o_spi_miso  <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_wr_en     <= wr_stb;
      o_frame_err <= frame_abort;
      // rx_shift holds rw + upper address bits when the 7th bit arrives.
      load_tx     <= cmd_done && rx_shift[AW-1];

      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        rx_shift <= {rx_shift[DW-3:0], mosi_sync};
      end

      if (cmd_done) begin
        rw_bit <= rx_shift[AW-1];
        addr   <= {rx_shift[AW-2:0], mosi_sync};
      end

      if (wr_stb) begin
        o_wr_addr <= addr;
        o_wr_data <= wr_data;
      end

      if (load_tx) begin
        tx_shift <= rd_data;
      end else if (tx_active && sclk_fall) begin
        tx_shift <= {tx_shift[DW-2:0], 1'b0};
      end

      if (tx_active) begin
        if (sclk_fall) o_spi_miso <= tx_shift[DW-1];
      end else begin
        o_spi_miso <= 1'b0;
      end
    end
  end

  assign o_busy        = (state != ST_IDLE);
  assign o_spi_miso_oe = (state != ST_IDLE);

  spi_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (REG_DEPTH)
  ) u_regfile (
    .clk     (i_clk_sys),
    .rst_n   (i_rst_n),
    .we      (wr_stb),
    .wr_addr (addr),
    .wr_data (wr_data),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter SPI_ADDR_WIDTH, default 6, meaning register address width.
REQ-002 SHALL have parameter SPI_DATA_WIDTH, default 20, meaning register data width.
REQ-003 SHALL have parameter REG_DEPTH, default 64, meaning number of implemented registers (2**SPI_ADDR_WIDTH).
REQ-004 SHALL have port i_clk_sys  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_spi_sclk  input  1  SPI clock from master, asynchronous to i_clk_sys.
REQ-007 SHALL have port i_spi_cs_n  input  1  chip select, active-low, asynchronous.
REQ-008 SHALL have port i_spi_mosi  input  1  serial data from master.
REQ-009 SHALL have port o_spi_miso  output  1  serial data to master.
REQ-010 SHALL have port o_spi_miso_oe  output  1  MISO drive enable, high only while selected.
REQ-011 SHALL have port o_wr_en  output  1  one-cycle strobe on each committed write.
REQ-012 SHALL have port o_wr_addr  output  SPI_ADDR_WIDTH  address of the committed write.
REQ-013 SHALL have port o_wr_data  output  SPI_DATA_WIDTH  data of the committed write.
REQ-014 SHALL have port o_frame_err  output  1  one-cycle strobe on an aborted frame.
REQ-015 SHALL have port o_busy  output  1  high while a frame is in progress.

Function
REQ-016 SHALL use SPI mode 0 with frame = rw bit (1=read, 0=write), then 6 address bits, then 20 data bits, all MSB first: 27 bits total.
REQ-017 SHALL pass sclk, cs_n and mosi through 2-FF synchronizers and detect sclk edges from the synchronized signal; minimum supported SCLK period = 8 i_clk_sys cycles.
REQ-018 SHALL sample MOSI on each synchronized SCLK rising edge and change MISO only on synchronized SCLK falling edges.
REQ-019 SHALL implement FSM IDLE -> CMD (7 bits) -> DATA (20 bits) -> DONE; synchronized CS_n fall moves IDLE->CMD; 7th rising edge moves CMD->DATA; 27th rising edge moves DATA->DONE; CS_n rise from any state returns to IDLE.
REQ-020 SHALL, on a read frame, load the tx shift register with reg[addr] in the cycle after the 7th rising edge and present the data MSB on o_spi_miso at the following falling edge, shifting one bit per falling edge.
REQ-021 SHALL, on a write frame, write reg[addr] <= data and pulse o_wr_en with o_wr_addr/o_wr_data valid exactly 1 cycle after the 27th rising edge.
REQ-022 SHALL drive o_spi_miso = 0 during CMD, during write frames, and after the 27th bit.
REQ-023 SHALL ignore extra SCLK edges beyond bit 27 while CS_n stays low (no second write, no counter wrap).
REQ-024 SHALL, on CS_n rise with 0 < bit count < 27, discard the frame with no register change and pulse o_frame_err for 1 cycle; CS_n rise with 0 bits SHALL NOT flag an error.
REQ-025 SHALL treat CS_n rise coincident with the 27th rising edge as a completed frame.
REQ-026 SHALL assert o_busy from the CS_n fall (synchronized) until the return to IDLE.

Reset
REQ-027 SHALL, on i_rst_n low, clear all registers to 0, synchronizers to idle (sclk=0, cs_n=1), FSM to IDLE, bit count to 0, and all outputs to 0.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame without write and without o_frame_err; after release, a frame SHALL start only on a fresh CS_n fall.

Structure
REQ-029 SHALL place the FSM state encodings, frame length (27) and the CMD length (7) constants in a shared package also used by the SPI master.
REQ-030 SHALL implement the register array as sub-module spi_slave_regfile (one write port, one asynchronous read port, reset to 0).

Verification
REQ-031 Write rw=0 addr 0x05 data 0xABCDE -> o_wr_en pulse, o_wr_addr=0x05, o_wr_data=0xABCDE, o_frame_err=0.
REQ-032 Then read rw=1 addr 0x05 -> MISO bits 8..27 = 0xABCDE MSB first; o_wr_en stays 0.
REQ-033 Read addr 0x3F after reset -> MISO data = 0x00000.
REQ-034 Write addr 0x05 data 0x12345 with CS_n raised after 15 bits -> o_frame_err pulse, no o_wr_en, later read of 0x05 returns 0xABCDE.
REQ-035 Two back-to-back writes (0x01<-0x00001, 0x02<-0xFFFFF), CS_n high for one SCLK period between -> two o_wr_en pulses with correct values; 30 SCLKs in one frame -> exactly one write.
REQ-036 Assert i_rst_n low after 10 bits of a write -> no write, no error, all outputs 0; next full frame operates normally.
